// File: rtl/fetch_decode_skid_buffer_pkg.sv
// ============================================================================
// Module   : fetch_decode_skid_buffer_pkg
// Brief    : Shared pipeline-stage defaults and entry layout for stage buffers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_decode_skid_buffer_pkg;

  localparam int c_PC_W    = 32;
  localparam int c_INSTR_W = 16;

  localparam logic [c_INSTR_W-1:0] c_NOP_INSTR = '0;

  // Entry layout shared by every stage buffer: pc on top, interrupt tag at bit 0.
  typedef struct packed {
    logic [c_PC_W-1:0]    pc;
    logic [c_INSTR_W-1:0] instr;
    logic                 interrupt;
  } fd_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_decode_skid_buffer_pipe_slot.sv
// ============================================================================
// Module   : fetch_decode_skid_buffer_pipe_slot
// Brief    : Single entry register with valid flag, load and clear controls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_decode_skid_buffer_pipe_slot #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Clear only drops the valid flag; the payload is left in place.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/fetch_decode_skid_buffer.sv
// ============================================================================
// Module   : fetch_decode_skid_buffer
// Brief    : Fetch-to-decode 2-entry skid buffer with flush and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_decode_skid_buffer
  import fetch_decode_skid_buffer_pkg::*;
#(
  parameter int                 PC_W      = c_PC_W,
  parameter int                 INSTR_W   = c_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_interrupt,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_interrupt,
  output logic [1:0]         o_count
);

  localparam int c_ENTRY_W = PC_W + INSTR_W + 1;

  logic                 w_main_v;
  logic                 w_skid_v;
  logic [c_ENTRY_W-1:0] w_main_data;
  logic [c_ENTRY_W-1:0] w_skid_data;
  logic [c_ENTRY_W-1:0] w_in_data;
  logic [c_ENTRY_W-1:0] w_main_in;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_main_upd;
  logic                 w_main_load;
  logic                 w_main_clear;
  logic                 w_skid_load;
  logic                 w_skid_clear;
  logic                 w_main_v_nxt;
  logic                 w_skid_v_nxt;
  logic [1:0]           r_count;

  assign w_in_data  = {i_pc, i_instr, i_interrupt};
  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = w_main_v & i_ready;
  assign w_main_upd = ~w_main_v | w_out_fire;

  // Skid content always has priority over fresh input to preserve order.
  assign w_main_in    = w_skid_v ? w_skid_data : w_in_data;
  assign w_main_load  = w_main_upd & (w_skid_v | w_in_fire);
  assign w_main_clear = i_flush | (w_main_upd & ~w_skid_v & ~w_in_fire);
  assign w_skid_load  = w_in_fire & w_main_v & ~i_ready;
  assign w_skid_clear = i_flush | (w_main_upd & w_skid_v);

  assign w_main_v_nxt = ~i_flush & (w_main_upd ? (w_skid_v | w_in_fire) : w_main_v);
  assign w_skid_v_nxt = ~i_flush & (w_skid_load | (w_skid_v & ~w_main_upd));

  fetch_decode_skid_buffer_pipe_slot #(.W(c_ENTRY_W)) u_main_slot (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_in),
    .o_valid (w_main_v),
    .o_data  (w_main_data)
  );

  fetch_decode_skid_buffer_pipe_slot #(.W(c_ENTRY_W)) u_skid_slot (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_in_data),
    .o_valid (w_skid_v),
    .o_data  (w_skid_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 2'd0;
    end else begin
      r_count <= {1'b0, w_main_v_nxt} + {1'b0, w_skid_v_nxt};
    end
  end

  assign o_ready     = ~w_skid_v;
  assign o_valid     = w_main_v;
  assign o_pc        = w_main_data[c_ENTRY_W-1 -: PC_W];
  assign o_instr     = w_main_v ? w_main_data[INSTR_W:1] : NOP_INSTR;
  assign o_interrupt = w_main_v & w_main_data[0];
  assign o_count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_skid_buffer.sv
// ============================================================================
// Module   : tb_fetch_decode_skid_buffer
// Brief    : Directed plus randomized bench against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_decode_skid_buffer;

  localparam logic [15:0] c_NOP = 16'h0000;

  logic        i_clk = 1'b0;
  logic        i_reset, i_flush, i_valid, i_ready, i_interrupt;
  logic [31:0] i_pc;
  logic [15:0] i_instr;
  logic        o_ready, o_valid, o_interrupt;
  logic [31:0] o_pc;
  logic [15:0] o_instr;
  logic [1:0]  o_count;

  fetch_decode_skid_buffer #(
    .PC_W      (32),
    .INSTR_W   (16),
    .NOP_INSTR (c_NOP)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_pc        (i_pc),
    .i_instr     (i_instr),
    .i_interrupt (i_interrupt),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_pc        (o_pc),
    .o_instr     (o_instr),
    .o_interrupt (o_interrupt),
    .o_count     (o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] instr;
    logic        intr;
  } ent_t;

  // Model: FIFO of at most two entries; the head is what decode sees.
  ent_t        q[$];
  logic [31:0] shown_pc;
  int          tests_run;
  int          tests_failed;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    check_eq("valid", {31'd0, o_valid}, (n > 0) ? 32'd1 : 32'd0);
    check_eq("ready", {31'd0, o_ready}, (n < 2) ? 32'd1 : 32'd0);
    check_eq("count", {30'd0, o_count}, n);
    check_eq("pc", o_pc, shown_pc);
    check_eq("instr", {16'd0, o_instr}, (n > 0) ? {16'd0, q[0].instr} : {16'd0, c_NOP});
    check_eq("intr", {31'd0, o_interrupt}, (n > 0) ? {31'd0, q[0].intr} : 32'd0);
  endtask

  task automatic step(input logic rst, input logic fl, input logic v, input logic rdy,
                      input logic [31:0] pc, input logic [15:0] ins, input logic intr);
    logic in_f, out_f;
    ent_t e;
    i_reset = rst; i_flush = fl; i_valid = v; i_ready = rdy;
    i_pc = pc; i_instr = ins; i_interrupt = intr;
    in_f  = v && (q.size() < 2);
    out_f = (q.size() > 0) && rdy;
    @(posedge i_clk);
    if (rst) begin
      q.delete();
      shown_pc = 32'd0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f) begin
        e = '{pc: pc, instr: ins, intr: intr};
        q.push_back(e);
      end
    end
    if (q.size() > 0) shown_pc = q[0].pc;
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, rdy, 32'h0, 16'h0, 1'b0);
  endtask

  logic        p_v, p_intr, acc;
  logic [31:0] p_pc;
  logic [15:0] p_ins;
  logic        r_rst, r_fl, r_rdy;

  initial begin
    tests_run = 0; tests_failed = 0; shown_pc = 32'd0;
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_pc = '0; i_instr = '0; i_interrupt = 1'b0;

    // Reset held two cycles with a valid entry offered
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 16'h1234, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 16'h1234, 1'b0);
    idle(1'b1);
    check_eq("rst_pc", o_pc, 32'h0);
    check_eq("rst_instr", {16'd0, o_instr}, 32'h0);

    // Streaming at full rate
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h10 + k, 16'hA001 + k[15:0], 1'b0);
    check_eq("stream_last_pc", o_pc, 32'h12);
    idle(1'b1);

    // Stall: second entry goes to skid, third is held upstream
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 16'hB000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h21, 16'hB001, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h22, 16'hB002, 1'b0);
    check_eq("stall_hold_pc", o_pc, 32'h20);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 16'hB002, 1'b0);
    check_eq("drain_pc1", o_pc, 32'h21);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 16'hB002, 1'b0);
    check_eq("drain_pc2", o_pc, 32'h22);
    idle(1'b1);

    // Flush with both slots full and a new entry offered
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h2A, 16'hC000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h2B, 16'hC001, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h30, 16'hC030, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Interrupt tag travels through the skid slot
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h3F, 16'hD000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 16'hD040, 1'b1);
    idle(1'b0);
    idle(1'b1);
    check_eq("intr_pc", o_pc, 32'h40);
    check_eq("intr_tag", {31'd0, o_interrupt}, 32'd1);
    idle(1'b1);

    // Reset while both slots are full
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h50, 16'hE000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h51, 16'hE001, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h52, 16'hE002, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic; fetch holds an entry until it is accepted
    p_v = 1'b0; p_pc = 32'h1000; p_ins = '0; p_intr = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!p_v || acc) begin
        p_v    = ($urandom_range(0, 3) != 0);
        p_pc   = p_pc + 32'd1;
        p_ins  = 16'($urandom);
        p_intr = ($urandom_range(0, 3) == 0);
      end
      r_rst = ($urandom_range(0, 99) < 2);
      r_fl  = ($urandom_range(0, 99) < 5);
      r_rdy = ($urandom_range(0, 9) < 6);
      acc   = p_v && (q.size() < 2) && !r_rst && !r_fl;
      step(r_rst, r_fl, p_v, r_rdy, p_pc, p_ins, p_intr);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial acc = 1'b0;

endmodule

`default_nettype wire

// File: doc/fetch_decode_skid_buffer.md
Name: fetch_decode_skid_buffer

Overview:
- Parametrised successor to the basic fetch/decode pipeline register.
- Sits between fetch and decode and carries {pc, instr, interrupt} per entry.
- Adds a valid/ready handshake, a 2-entry skid (main + skid slot) so fetch sees a registered ready, a synchronous flush for branch/interrupt redirect, and an occupancy output.
- Empty slots present a NOP to decode.

Parameters:
- PC_W, 32, width of program counter field
- INSTR_W, 16, width of instruction field
- NOP_INSTR, {INSTR_W{1'b0}}, encoding driven on o_instr when main slot empty or after reset/flush

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_flush  in  1  discard all held entries (branch taken / interrupt redirect)
- i_valid  in  1  fetch presents a valid entry
- o_ready  out  1  buffer can accept an entry this cycle (registered)
- i_pc  in  PC_W  fetched pc
- i_instr  in  INSTR_W  fetched instruction
- i_interrupt  in  1  interrupt tag travelling with entry
- o_valid  out  1  main slot holds a valid entry
- i_ready  in  1  decode consumes main slot this cycle
- o_pc  out  PC_W  main slot pc
- o_instr  out  INSTR_W  main slot instruction (NOP_INSTR when o_valid=0)
- o_interrupt  out  1  main slot interrupt tag (0 when o_valid=0)
- o_count  out  2  occupancy 0..2

Behaviour:
- Reset is synchronous, active-high on i_reset, clock i_clk. Priority: i_reset > i_flush > normal operation.
- Reset values: o_valid=0, o_pc=0, o_instr=NOP_INSTR, o_interrupt=0, skid slot invalid and zeroed, o_ready=1, o_count=0.
- Transfers:
  - in_fire = i_valid & o_ready
  - out_fire = o_valid & i_ready
  - i_valid must not depend combinationally on o_ready. o_ready = ~skid_valid, from a flop.
- Main slot update, applied when main empty or out_fire:
  - load skid if skid valid;
  - else load input if in_fire;
  - else go empty (o_valid=0, o_instr=NOP_INSTR, o_pc holds, o_interrupt=0).
- Skid slot:
  - Captures the input when in_fire & o_valid & ~i_ready (main stalled).
  - Is cleared when its content moves to main.
  - Cannot be loaded while valid, because o_ready=0 then.
- Latency: entry accepted at cycle N appears on o_* at N+1 when the buffer was empty or draining.
- Full throughput: sustained 1 entry/cycle with i_ready=1 and i_valid=1; skid stays empty.
- Stall: with i_ready=0, main holds its values stable.
  - One extra entry is absorbed into skid; o_ready drops the next cycle.
  - On release, skid drains into main first (order preserved); o_ready rises the cycle after skid empties.
- Flush: i_flush=1 at edge N clears both slots.
  - At N+1: o_valid=0, o_instr=NOP_INSTR, o_interrupt=0, o_count=0, o_ready=1.
  - Any in_fire in the flush cycle is discarded, not stored.
  - out_fire in the flush cycle is still a legal consumption by decode.
- Simultaneous in_fire & out_fire with skid empty: main replaced by the input, count unchanged.
- Reset mid-stall (both slots full): both slots dropped, reset values next cycle.
- o_count = o_valid + skid_valid, registered, consistent with the slots every cycle.
- Interrupt tag is never merged or dropped except by flush/reset; it moves strictly with its entry.

Decomposition:
- Shared pipeline package: NOP_INSTR default, PC_W/INSTR_W defaults, packed entry typedef {pc, instr, interrupt}, reused by later stage buffers.
- One natural sub-module, pipe_slot: a single entry register with valid, load, clear. Instantiate it twice (main, skid), with control logic in the parent.

Test Plan:
- Reset held 2 cycles with i_valid=1, i_pc=0x100 -> o_valid=0, o_instr=0x0000, o_pc=0, o_ready=1, o_count=0 after release.
- Streaming with i_ready=1: i_pc=0x10,0x11,0x12 on consecutive cycles with instrs 0xA001..0xA003 -> o_pc 0x10,0x11,0x12 one cycle later each, o_count=1, o_ready stays 1.
- Stall: i_ready=0 while feeding 0x20,0x21,0x22 -> o_pc holds 0x20, 0x21 goes to skid, o_ready=0 from next cycle, o_count=2, and 0x22 is held upstream. i_ready=1 -> outputs 0x21 then 0x22 in order, o_ready returns to 1.
- Flush with both slots full plus i_valid=1 (pc 0x30) -> next cycle o_valid=0, o_instr=NOP, o_count=0, o_ready=1, and 0x30 never appears.
- Interrupt tag: entry pc 0x40 with i_interrupt=1 stalled in skid -> o_interrupt=1 exactly when o_pc=0x40, 0 otherwise.
- Reset asserted mid-stall with count=2 -> next cycle all outputs at reset values, and no stale entry emerges afterward.
